fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: word address of the first instruction fetched after reset.
REQ-002 SHALL have parameter IMEM_AW, default 11: instruction-memory word-address width.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous reset, active-high.
REQ-005 SHALL have port stall_f, input, 1: decode not ready; the head instruction is held.
REQ-006 SHALL have port branch_valid, input, 1: redirect request from execute.
REQ-007 SHALL have port branch_target, input, 32: redirect word address.
REQ-008 SHALL have port imem_addr, output, IMEM_AW: instruction-memory read address.
REQ-009 SHALL have port imem_rdata, input, 32: memory data, valid 2 cycles after its address was presented.
REQ-010 SHALL have port instr_out, output, 32: head instruction to decode.
REQ-011 SHALL have port pc_out, output, 32: word address of instr_out.
REQ-012 SHALL have port instr_valid, output, 1: instr_out and pc_out are valid.

Function
REQ-013 SHALL hold a 32-bit PC; imem_addr SHALL equal PC[IMEM_AW-1:0] in every cycle.
REQ-014 SHALL issue one fetch per cycle when (buffer count + in-flight count) < 4 and branch_valid=0; each issue SHALL increment PC by 1, wrapping modulo 2^32.
REQ-015 SHALL track in-flight fetches in a 2-stage valid/PC shift register; a stage that exits valid SHALL push {imem_rdata, its PC} into the buffer at the end of that cycle.
REQ-016 SHALL buffer up to 4 entries FIFO-ordered; instr_out, pc_out and instr_valid SHALL be driven from the head entry, registered.
REQ-017 SHALL pop the head when instr_valid=1 and stall_f=0; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-018 SHALL keep instr_out and pc_out stable while instr_valid=1 and stall_f=1.
REQ-019 SHALL never overflow the buffer, because REQ-014 reserves a slot for every in-flight fetch.
REQ-020 On branch_valid=1, SHALL load PC with branch_target, empty the buffer, clear all in-flight valid bits and issue no fetch in that cycle; branch_valid SHALL take priority over pop, push, issue and stall_f.
REQ-021 Redirect latency: branch_valid in cycle r SHALL give instr_valid=0 in cycles r+1..r+3 and the target instruction in cycle r+4 (load_pc, fetch, fetch_wait, decode).
REQ-022 No instruction fetched before a redirect SHALL ever appear on the outputs after it.
REQ-023 Steady-state throughput with stall_f=0 SHALL be one instruction per cycle with no bubbles.

Reset
REQ-024 With rst=1 at a rising edge: PC=RESET_PC, buffer empty, in-flight valid bits cleared, instr_valid=0, instr_out=0, pc_out=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; REQ-021 timing SHALL then apply with the first cycle with rst=0 taken as cycle r+1.

Structure
REQ-026 FETCH_BUF_DEPTH=4, IMEM_LATENCY=2 and the fetch-entry struct {pc[31:0], instr[31:0]} SHALL live in the shared CPU package.
REQ-027 The buffer SHALL be the sub-module fetch_fifo: 4-entry synchronous FIFO with push, pop and a flush input; count SHALL be visible to the parent.

Verification
REQ-028 Reset release with mem[k]=k+100 and stall_f=0: imem_addr=0,1,2,... from cycle 1; cycle 4 instr_out=100, pc_out=0; then 101/1, 102/2 in consecutive cycles.
REQ-029 stall_f=1 for 6 cycles once instr 100 is valid: output holds 100/0; at most 4 entries are buffered plus in flight; after release, 101, 102, ... arrive with no gap and no duplicate.
REQ-030 branch_valid=1 with target 16 in cycle r: instr_valid=0 in cycles r+1..r+3; cycle r+4 instr_out=116, pc_out=16; then 117/17.
REQ-031 Redirect with the buffer full and stall_f=1: the buffer flushes and the target output follows REQ-030 timing.
REQ-032 Redirects in cycles r (target 8) and r+2 (target 40): no instruction from target 8 is output; instr_out=140, pc_out=40 in cycle r+6.
REQ-033 rst pulse mid-stream: instr_valid=0 in the following cycle; the stream restarts at pc_out=0 with REQ-028 timing.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared CPU package: fetch buffer sizing and fetch-entry type
package fetch_unit_pkg;

    localparam int FETCH_BUF_DEPTH = 4;
    localparam int IMEM_LATENCY    = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - 4-entry synchronous fetch buffer with push, pop and flush
module fetch_fifo
    import fetch_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [2:0]   count
);

    localparam int PTR_W = $clog2(FETCH_BUF_DEPTH);

    fetch_entry_t     mem [FETCH_BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even though the parent reserves slots
    always_comb begin
        do_push = push && (count != 3'(FETCH_BUF_DEPTH));
        do_pop  = pop && (count != 3'd0);
    end

    // Pointer and occupancy update; flush discards everything in one cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, in-flight tracking, redirect and fetch buffer
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          IMEM_AW  = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f,
    input  logic               branch_valid,
    input  logic [31:0]        branch_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc_out,
    output logic               instr_valid
);

    logic [31:0]             pc;
    logic [IMEM_LATENCY-1:0] stage_valid;
    logic [31:0]             stage_pc [IMEM_LATENCY];
    logic [2:0]              inflight;
    logic [2:0]              buf_count;
    logic [3:0]              occupancy;
    logic                    issue;
    logic                    push;
    logic                    pop;
    fetch_entry_t            push_data;
    fetch_entry_t            head;

    assign imem_addr = pc[IMEM_AW-1:0];

    // Issue only when every in-flight fetch is guaranteed a buffer slot
    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            inflight = inflight + {2'b00, stage_valid[i]};
        end
        occupancy = {1'b0, buf_count} + {1'b0, inflight};
        issue     = !branch_valid && (occupancy < 4'(FETCH_BUF_DEPTH));
        push      = stage_valid[IMEM_LATENCY-1] && !branch_valid;
        pop       = instr_valid && !stall_f;
        push_data = '{pc: stage_pc[IMEM_LATENCY-1], instr: imem_rdata};
    end

    // PC and in-flight pipeline; a redirect kills everything still in memory
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            stage_valid <= '0;
            for (int i = 0; i < IMEM_LATENCY; i++) begin
                stage_pc[i] <= 32'd0;
            end
        end else if (branch_valid) begin
            pc          <= branch_target;
            stage_valid <= '0;
        end else begin
            stage_valid <= {stage_valid[IMEM_LATENCY-2:0], issue};
            stage_pc[0] <= pc;
            for (int i = 1; i < IMEM_LATENCY; i++) begin
                stage_pc[i] <= stage_pc[i-1];
            end
            if (issue) begin
                pc <= pc + 32'd1;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (branch_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (buf_count)
    );

    // Head entry straight from buffer registers; zeroed when nothing is valid
    always_comb begin
        instr_valid = (buf_count != 3'd0);
        instr_out   = instr_valid ? head.instr : 32'd0;
        pc_out      = instr_valid ? head.pc : 32'd0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_f;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    logic [10:0] addr_q;
    logic [31:0] rdata_q;

    int checks;
    int errors;

    fetch_unit #(.RESET_PC(32'd0), .IMEM_AW(11)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_f       (stall_f),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Two-cycle memory: mem[k] = k + 100
    always @(posedge clk) begin
        addr_q  <= imem_addr;
        rdata_q <= {21'd0, addr_q} + 32'd100;
    end
    assign imem_rdata = rdata_q;

    // Leaves the bench mid-cycle 1 (first cycle with rst=0)
    task automatic do_reset();
        rst = 1'b1;
        stall_f = 1'b0;
        branch_valid = 1'b0;
        branch_target = 32'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stall_f = 1'b0;
        branch_valid = 1'b0;
        branch_target = 32'd0;
        skip(3);
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", instr_valid); end
        checks++;
        if (instr_out !== 32'd0) begin errors++; $display("FAIL reset_instr got=%0d exp=0", instr_out); end
        checks++;
        if (pc_out !== 32'd0) begin errors++; $display("FAIL reset_pc got=%0d exp=0", pc_out); end
        checks++;
        if (imem_addr !== 11'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
    endtask

    task automatic test_startup();
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if (imem_addr !== 11'(c - 1)) begin errors++; $display("FAIL startup_addr cyc=%0d got=%0d exp=%0d", c, imem_addr, c - 1); end
            checks++;
            if (instr_valid !== (c >= 4)) begin errors++; $display("FAIL startup_valid cyc=%0d got=%0b exp=%0b", c, instr_valid, c >= 4); end
            if (c >= 4) begin
                checks++;
                if (instr_out !== 32'(100 + c - 4)) begin errors++; $display("FAIL startup_instr cyc=%0d got=%0d exp=%0d", c, instr_out, 100 + c - 4); end
                checks++;
                if (pc_out !== 32'(c - 4)) begin errors++; $display("FAIL startup_pc cyc=%0d got=%0d exp=%0d", c, pc_out, c - 4); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        do_reset();
        skip(3);
        // cycles 4..9 stalled, cycle 10 released: output holds 100/0 through cycle 10
        for (int c = 4; c <= 10; c++) begin
            stall_f = (c <= 9);
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'd100 || pc_out !== 32'd0) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%0b/%0d/%0d exp=1/100/0", c, instr_valid, instr_out, pc_out);
            end
            if (c >= 5) begin
                checks++;
                if (imem_addr !== 11'd4) begin errors++; $display("FAIL stall_no_issue cyc=%0d got=%0d exp=4", c, imem_addr); end
            end
            @(negedge clk);
        end
        stall_f = 1'b0;
        for (int c = 11; c <= 18; c++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'(101 + c - 11) || pc_out !== 32'(1 + c - 11)) begin
                errors++; $display("FAIL stall_resume cyc=%0d got=%0b/%0d/%0d exp=1/%0d/%0d", c, instr_valid, instr_out, pc_out, 101 + c - 11, 1 + c - 11);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        do_reset();
        skip(5);
        branch_valid = 1'b1;
        branch_target = 32'd16;
        @(negedge clk);
        branch_valid = 1'b0;
        checks++;
        if (imem_addr !== 11'd16) begin errors++; $display("FAIL branch_addr got=%0d exp=16", imem_addr); end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch_bubble r+%0d got=%0b exp=0", k, instr_valid); end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'(116 + k) || pc_out !== 32'(16 + k)) begin
                errors++; $display("FAIL branch_target r+%0d got=%0b/%0d/%0d exp=1/%0d/%0d", 4 + k, instr_valid, instr_out, pc_out, 116 + k, 16 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_full();
        do_reset();
        skip(3);
        stall_f = 1'b1;
        skip(5);
        checks++;
        if (instr_out !== 32'd100 || imem_addr !== 11'd4) begin
            errors++; $display("FAIL full_setup got=%0d/%0d exp=100/4", instr_out, imem_addr);
        end
        branch_valid = 1'b1;
        branch_target = 32'd16;
        @(negedge clk);
        branch_valid = 1'b0;
        stall_f = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL full_flush r+%0d got=%0b exp=0", k, instr_valid); end
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'(116 + k) || pc_out !== 32'(16 + k)) begin
                errors++; $display("FAIL full_target r+%0d got=%0b/%0d/%0d exp=1/%0d/%0d", 4 + k, instr_valid, instr_out, pc_out, 116 + k, 16 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        skip(6);
        branch_valid = 1'b1;
        branch_target = 32'd8;
        @(negedge clk);
        branch_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                branch_valid = 1'b1;
                branch_target = 32'd40;
            end else begin
                branch_valid = 1'b0;
            end
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble r+%0d got=%0b/%0d exp=0", k, instr_valid, pc_out); end
            @(negedge clk);
        end
        branch_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'(140 + k) || pc_out !== 32'(40 + k)) begin
                errors++; $display("FAIL b2b_target r+%0d got=%0b/%0d/%0d exp=1/%0d/%0d", 6 + k, instr_valid, instr_out, pc_out, 140 + k, 40 + k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        skip(7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (imem_addr !== 11'd0) begin errors++; $display("FAIL midrst_addr got=%0d exp=0", imem_addr); end
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_bubble r+%0d got=%0b exp=0", k, instr_valid); end
            @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== 32'(100 + k) || pc_out !== 32'(k)) begin
                errors++; $display("FAIL midrst_stream r+%0d got=%0b/%0d/%0d exp=1/%0d/%0d", 4 + k, instr_valid, instr_out, pc_out, 100 + k, k);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_startup();
        test_stall();
        test_branch();
        test_branch_full();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
